// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 256-way round-robin arbiter.
package arb_pkg;
  localparam int N     = 256;
  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Circular first-one picker: lowest set req bit at or above ptr, else lowest set bit overall.
module rr_pick #(
  parameter int N     = arb_pkg::N,
  parameter int IDX_W = arb_pkg::IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic             any
);
  logic [N-1:0] masked;
  logic [N-1:0] masked_low;
  logic [N-1:0] req_low;

  // x & -x isolates the lowest set bit; the masked search wins when non-empty
  always_comb begin
    masked     = req & ({N{1'b1}} << ptr);
    masked_low = masked & (~masked + N'(1));
    req_low    = req & (~req + N'(1));
    sel        = (|masked) ? masked_low : req_low;
    any        = |req;
  end
endmodule

// File: rtl/rr_arbiter_256.sv
// Round-robin arbiter with registered one-hot grant and ack handshake.
// Optional grant locking is compiled in with `define RR_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate among req on the next edge
// GRANT | gnt holds a one-hot grant until gnt_ack
module rr_arbiter_256 #(
  parameter int N     = arb_pkg::N,
  parameter int IDX_W = arb_pkg::IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  input  logic         gnt_ack
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic         lock
`endif
);
  import arb_pkg::*;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [N-1:0]     pick_sel;
  logic             pick_any;
  logic [IDX_W-1:0] gnt_idx;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // gnt_q is one-hot, so OR-ing indices of set bits yields the granted index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) gnt_idx = gnt_idx | IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_sel;
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ack) begin
`ifdef RR_ARB_LOCK_EN
          ptr_d = lock ? gnt_idx : gnt_idx + IDX_W'(1);
`else
          ptr_d = gnt_idx + IDX_W'(1);
`endif
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
endmodule
